shift_reg_n: RTL and testbench
==============================

SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset and clear.
REQ-003 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  operation enable; low = hold all state.
REQ-006 SHALL have port mode  input  3  operation select, per REQ-011.
REQ-007 SHALL have port sin  input  1  serial data in.
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port q  output  WIDTH  registered contents; qb output WIDTH, combinational ~q.
REQ-010 SHALL have ports sout output 1 serial out and frame_done output 1 registered one-cycle pulse.

Function
REQ-011 SHALL decode mode when en=1 at rising clk: 000 hold; 001 shift left (q <= {q[W-2:0],sin}); 010 shift right (q <= {sin,q[W-1:1]}); 011 parallel load (q <= d); 100 rotate left; 101 rotate right; 110 clear (q <= RESET_VAL); 111 hold.
REQ-012 SHALL hold q, direction flag, counter when en=0; frame_done SHALL be 0 the following cycle.
REQ-013 SHALL keep a registered direction flag dir: set 0 by shift/rotate left, 1 by shift/rotate right, unchanged otherwise.
REQ-014 SHALL drive sout combinationally = q[WIDTH-1] when dir=0, q[0] when dir=1.
REQ-015 SHALL count shift/rotate operations in a counter of width clog2(WIDTH), range 0..WIDTH-1.
REQ-016 SHALL, on a shift/rotate op whose direction equals dir, increment the counter; at WIDTH-1 it wraps to 0 and frame_done pulses high in the next cycle for exactly one cycle.
REQ-017 SHALL, on a shift/rotate op whose direction differs from dir, set counter to 1 (current op counts), no frame_done.
REQ-018 SHALL, on parallel load or clear, set counter to 0 with no frame_done pulse; hold modes leave counter unchanged.
REQ-019 SHALL produce one-clock latency from operation edge to updated q, dir, counter; frame_done asserts in the cycle q holds the WIDTHth shifted value.
REQ-020 SHALL allow back-to-back frames: frame_done may pulse every WIDTH enabled shift cycles with no gap.

Reset
REQ-021 SHALL, when rst=1 at rising clk, set q=RESET_VAL, dir=0, counter=0, frame_done=0, overriding en and mode.
REQ-022 SHALL abandon any partial frame on reset mid-frame; counting restarts from 0 after rst deasserts.
REQ-023 SHALL have undefined-free outputs from the first clk edge with rst=1; no asynchronous path from rst.

Configuration
REQ-024 SHALL support macro SHIFT_REG_N_ROTATE_EN: defined, modes 100/101 rotate (MSB->LSB left, LSB->MSB right, sin ignored) and count per REQ-016/017.
REQ-025 SHALL, with SHIFT_REG_N_ROTATE_EN undefined, treat modes 100/101 as hold: q, dir, counter unchanged, no frame_done.

Verification
REQ-026 SHALL cover reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 one edge -> q=8'hA5, qb=8'h5A, frame_done=0, sout=1.
REQ-027 SHALL cover serial frame: clear, then 8 edges mode=001 with sin=1,0,1,1,0,0,1,0 -> q=8'hB2, frame_done=1 exactly one cycle after 8th edge.
REQ-028 SHALL cover direction change: 3 edges mode=001 then 1 edge mode=010 -> dir=1, counter=1, no frame_done until 7 further right shifts.
REQ-029 SHALL cover enable and load: load d=8'h3C, mode=001 with en=0 for 5 edges -> q stays 8'h3C, counter 0, no pulse.
REQ-030 SHALL cover rotate: with macro, q=8'h81, mode=100 one edge -> q=8'h03; without macro -> q stays 8'h81.
REQ-031 SHALL cover reset mid-frame: 5 left shifts, rst 1 edge, 8 left shifts -> frame_done only after the 8th post-reset shift.

Source files
------------

// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit universal shift register with serial/parallel I/O,
// a direction flag, a shift counter and a one-cycle frame_done pulse that
// fires after WIDTH same-direction shift/rotate operations.
// Optional feature macro: SHIFT_REG_N_ROTATE_EN (modes 100/101 rotate when
// defined, hold when undefined).
module shift_reg_n #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout,
   output logic             frame_done
);

   localparam int unsigned    CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;

   logic [WIDTH-1:0] r_q;
   logic             r_dir;      // 0 = left, 1 = right
   logic [CW-1:0]    r_cnt;
   logic             r_frame_done;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_dir_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_done_nxt;
   logic             w_is_shift;
   logic             w_op_dir;

   // Decode the requested operation and compute next state.
   always_comb begin
      w_q_nxt    = r_q;
      w_dir_nxt  = r_dir;
      w_cnt_nxt  = r_cnt;
      w_done_nxt = 1'b0;
      w_is_shift = 1'b0;
      w_op_dir   = 1'b0;

      if (en) begin
         case (mode)
            MODE_SHL: begin
               w_q_nxt    = {r_q[WIDTH-2:0], sin};
               w_is_shift = 1'b1;
               w_op_dir   = 1'b0;
            end
            MODE_SHR: begin
               w_q_nxt    = {sin, r_q[WIDTH-1:1]};
               w_is_shift = 1'b1;
               w_op_dir   = 1'b1;
            end
            MODE_LOAD: begin
               w_q_nxt   = d;
               w_cnt_nxt = '0;
            end
`ifdef SHIFT_REG_N_ROTATE_EN
            MODE_ROL: begin
               w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_is_shift = 1'b1;
               w_op_dir   = 1'b0;
            end
            MODE_ROR: begin
               w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
               w_is_shift = 1'b1;
               w_op_dir   = 1'b1;
            end
`endif
            MODE_CLR: begin
               w_q_nxt   = RESET_VAL;
               w_cnt_nxt = '0;
            end
            MODE_HOLD: ;
            default: ;  // 111 hold; 100/101 hold when rotate is not built in
         endcase
      end

      // A direction change restarts the frame with the current op counted.
      if (w_is_shift) begin
         w_dir_nxt = w_op_dir;
         if (w_op_dir == r_dir) begin
            if (r_cnt == CNT_MAX) begin
               w_cnt_nxt  = '0;
               w_done_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end else begin
            w_cnt_nxt = CW'(1);
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q          <= RESET_VAL;
         r_dir        <= 1'b0;
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_q          <= w_q_nxt;
         r_dir        <= w_dir_nxt;
         r_cnt        <= w_cnt_nxt;
         r_frame_done <= w_done_nxt;
      end
   end

   assign q          = r_q;
   assign qb         = ~r_q;
   assign sout       = r_dir ? r_q[0] : r_q[WIDTH-1];
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed self-checking bench for shift_reg_n (WIDTH=8, RESET_VAL=8'hA5).
// Expected values follow SHIFT_REG_N_ROTATE_EN when it is defined.
module tb_shift_reg_n;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] mode;
   logic       sin;
   logic [7:0] d;
   logic [7:0] q;
   logic [7:0] qb;
   logic       sout;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_reg_n #(
      .WIDTH     (8),
      .RESET_VAL (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .sin        (sin),
      .d          (d),
      .q          (q),
      .qb         (qb),
      .sout       (sout),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] bits;

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      mode = 3'b000;
      sin  = 1'b0;
      d    = 8'h00;
      bits = 8'b1011_0010;

      // Reset state
      step();
      check_eq("rst_q", 32'(q), 32'h A5);
      check_eq("rst_qb", 32'(qb), 32'h5A);
      check_eq("rst_fd", 32'(frame_done), 32'd0);
      check_eq("rst_sout", 32'(sout), 32'd1);
      rst = 1'b0;

      // Clear then an 8-bit serial frame, left
      en   = 1'b1;
      mode = 3'b110;
      step();
      check_eq("clr_q", 32'(q), 32'hA5);
      check_eq("clr_cnt", 32'(dut.r_cnt), 32'd0);
      mode = 3'b001;
      for (int i = 0; i < 8; i++) begin
         sin = bits[7-i];
         step();
         if (i < 7) check_eq($sformatf("frame_fd%0d", i), 32'(frame_done), 32'd0);
      end
      check_eq("frame_q", 32'(q), 32'hB2);
      check_eq("frame_fd", 32'(frame_done), 32'd1);
      check_eq("frame_sout", 32'(sout), 32'd1);
      mode = 3'b000;
      step();
      check_eq("frame_fd_off", 32'(frame_done), 32'd0);
      check_eq("hold_q", 32'(q), 32'hB2);

      // Back-to-back frames: pulses after the 8th and 16th shift only
      mode = 3'b001;
      sin  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         check_eq($sformatf("b2b_fd%0d", i), 32'(frame_done),
                  (i == 7 || i == 15) ? 32'd1 : 32'd0);
      end
      check_eq("b2b_q", 32'(q), 32'h00);

      // Direction change: 3 left, 1 right, then 7 more right
      sin = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_eq("dir_q3", 32'(q), 32'h07);
      check_eq("dir_cnt3", 32'(dut.r_cnt), 32'd3);
      mode = 3'b010;
      sin  = 1'b0;
      step();
      check_eq("dir_q", 32'(q), 32'h03);
      check_eq("dir_flag", 32'(dut.r_dir), 32'd1);
      check_eq("dir_cnt", 32'(dut.r_cnt), 32'd1);
      check_eq("dir_fd", 32'(frame_done), 32'd0);
      check_eq("dir_sout", 32'(sout), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step();
         check_eq($sformatf("dir_fd%0d", i), 32'(frame_done), (i == 6) ? 32'd1 : 32'd0);
      end

      // Load then enable low
      mode = 3'b011;
      d    = 8'h3C;
      step();
      check_eq("load_q", 32'(q), 32'h3C);
      check_eq("load_cnt", 32'(dut.r_cnt), 32'd0);
      check_eq("load_sout", 32'(sout), 32'd0);
      en   = 1'b0;
      mode = 3'b001;
      sin  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq($sformatf("en0_fd%0d", i), 32'(frame_done), 32'd0);
      end
      check_eq("en0_q", 32'(q), 32'h3C);
      check_eq("en0_cnt", 32'(dut.r_cnt), 32'd0);
      check_eq("en0_dir", 32'(dut.r_dir), 32'd1);

      // Rotate (or hold without the feature)
      en   = 1'b1;
      mode = 3'b011;
      d    = 8'h81;
      step();
      mode = 3'b100;
      step();
`ifdef SHIFT_REG_N_ROTATE_EN
      check_eq("rol_q", 32'(q), 32'h03);
      check_eq("rol_cnt", 32'(dut.r_cnt), 32'd1);
      check_eq("rol_dir", 32'(dut.r_dir), 32'd0);
`else
      check_eq("rol_q", 32'(q), 32'h81);
      check_eq("rol_cnt", 32'(dut.r_cnt), 32'd0);
      check_eq("rol_dir", 32'(dut.r_dir), 32'd1);
`endif
      mode = 3'b101;
      step();
      check_eq("ror_q", 32'(q), 32'h81);
      check_eq("ror_fd", 32'(frame_done), 32'd0);
      mode = 3'b111;
      step();
      check_eq("hold7_q", 32'(q), 32'h81);

      // Reset mid-frame
      mode = 3'b001;
      sin  = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      check_eq("mid_rst_q", 32'(q), 32'hA5);
      check_eq("mid_rst_cnt", 32'(dut.r_cnt), 32'd0);
      check_eq("mid_rst_dir", 32'(dut.r_dir), 32'd0);
      check_eq("mid_rst_fd", 32'(frame_done), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq($sformatf("mid_fd%0d", i), 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
      end
      check_eq("mid_q", 32'(q), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
